// File: rtl/cnn_probe_pkg.sv
// Shared types and width helpers for the CNN layer probe.
package cnn_probe_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } probe_state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB position of lane k on a packed multi-lane bus.
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/cnn_layer_probe_buf.sv
// Capture buffer: one write port, one read port, lane select and range masking after the read.
module probe_buf
  import cnn_probe_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 40,
  parameter int DEPTH      = 64,
  parameter int AW         = 6,
  parameter int CH_W       = 6,
  parameter bit REG_RAM_RD = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W*NUM_CH-1:0] wr_data,
  input  logic [AW-1:0]            rd_addr,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic                     rd_ok,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int W = DATA_W * NUM_CH;

  logic [W-1:0]      r_mem [DEPTH];
  logic [W-1:0]      w_word;
  logic [CH_W-1:0]   w_ch;
  logic              w_ok;
  logic [DATA_W-1:0] w_lanes [NUM_CH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  generate
    if (REG_RAM_RD) begin : g_bram_rd
      // Block-RAM style: word register first, select and range flag delayed to match.
      logic [W-1:0]    r_word;
      logic [CH_W-1:0] r_ch;
      logic            r_ok;
      always_ff @(posedge clk) begin
        r_word <= r_mem[rd_addr];
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ch <= '0;
          r_ok <= 1'b0;
        end else begin
          r_ch <= rd_ch;
          r_ok <= rd_ok;
        end
      end
      assign w_word = r_word;
      assign w_ch   = r_ch;
      assign w_ok   = r_ok;
    end else begin : g_dist_rd
      assign w_word = r_mem[rd_addr];
      assign w_ch   = rd_ch;
      assign w_ok   = rd_ok;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      assign w_lanes[gi] = w_word[lane_lsb(gi, DATA_W) +: DATA_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= w_ok ? w_lanes[w_ch] : '0;
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/cnn_layer_probe.sv
// Debug probe for a CNN layer output bus: beat capture with readback and arm-to-first-valid latency stats.
module cnn_layer_probe
  import cnn_probe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 40,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              arm,
  input  logic                              data_vld,
  input  logic [DATA_W*NUM_CH-1:0]          data_i,
  input  logic [clog2_min1(DEPTH)-1:0]      rd_beat,
  input  logic [clog2_min1(NUM_CH)-1:0]     rd_ch,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              busy,
  output logic                              cap_done,
  output logic [$clog2(DEPTH):0]            cap_cnt,
  output logic [CNT_W-1:0]                  lat_last,
  output logic [CNT_W-1:0]                  lat_min,
  output logic [CNT_W-1:0]                  lat_max,
  output logic                              lat_ovf
);

  localparam int AW   = clog2_min1(DEPTH);
  localparam int CH_W = clog2_min1(NUM_CH);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [CNT_W-1:0] LAT_MAX = '1;

  probe_state_e     r_state, w_state_next;
  logic [CW-1:0]    r_cap_cnt;
  logic [CNT_W-1:0] r_timer, r_lat_last, r_lat_min, r_lat_max;
  logic             r_lat_ovf;

  logic             w_take, w_first, w_rd_ok;
  logic [CW-1:0]    w_cap_cnt_inc;
  logic [CNT_W-1:0] w_lat_meas;

  // arm always wins over a coincident valid beat.
  assign w_take  = data_vld && !arm && ((r_state == S_WAIT) || (r_state == S_CAPTURE));
  assign w_first = data_vld && !arm && (r_state == S_WAIT);
  assign w_cap_cnt_inc = r_cap_cnt + CW'(1);
  // Latency of a valid seen now: the timer holds cycles already spent in WAIT.
  assign w_lat_meas = (r_timer == LAT_MAX) ? LAT_MAX : r_timer + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (arm) begin
      w_state_next = S_WAIT;
    end else begin
      case (r_state)
        S_WAIT, S_CAPTURE: begin
          if (data_vld) w_state_next = (w_cap_cnt_inc == DEPTH_C) ? S_DONE : S_CAPTURE;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_cnt  <= '0;
      r_timer    <= '0;
      r_lat_last <= '0;
      r_lat_min  <= '1;
      r_lat_max  <= '0;
      r_lat_ovf  <= 1'b0;
    end else begin
      if (arm)         r_cap_cnt <= '0;
      else if (w_take) r_cap_cnt <= w_cap_cnt_inc;

      if (arm) begin
        r_timer <= '0;
      end else if ((r_state == S_WAIT) && !data_vld) begin
        r_timer <= w_lat_meas;
        if (w_lat_meas == LAT_MAX) r_lat_ovf <= 1'b1;
      end

      if (w_first) begin
        r_lat_last <= w_lat_meas;
        if (w_lat_meas < r_lat_min) r_lat_min <= w_lat_meas;
        if (w_lat_meas > r_lat_max) r_lat_max <= w_lat_meas;
        if (w_lat_meas == LAT_MAX)  r_lat_ovf <= 1'b1;
      end
    end
  end

  assign w_rd_ok = (32'(rd_beat) < 32'(r_cap_cnt)) && (32'(rd_ch) < NUM_CH);

  probe_buf #(
    .DATA_W     (DATA_W),
    .NUM_CH     (NUM_CH),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .CH_W       (CH_W),
    .REG_RAM_RD (1'b0)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_take),
    .wr_addr (r_cap_cnt[AW-1:0]),
    .wr_data (data_i),
    .rd_addr (rd_beat),
    .rd_ch   (rd_ch),
    .rd_ok   (w_rd_ok),
    .rd_data (rd_data)
  );

  assign busy     = (r_state == S_WAIT) || (r_state == S_CAPTURE);
  assign cap_done = (r_state == S_DONE);
  assign cap_cnt  = r_cap_cnt;
  assign lat_last = r_lat_last;
  assign lat_min  = r_lat_min;
  assign lat_max  = r_lat_max;
  assign lat_ovf  = r_lat_ovf;

endmodule
